div_ratio_ctrl: RTL and testbench

DIV_RATIO_CTRL -- requirements
Module: div_ratio_ctrl

---
 rtl/div_ratio_ctrl.sv | 101 ++++++++++
 tb/tb_div_ratio_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/div_ratio_ctrl.sv
// Sequences ratio changes for a downstream clock divider: gates CLK_EN off,
// drains, loads the new DIV_RATIO, and settles before re-enabling.
module div_ratio_ctrl #(
    parameter int RESET_RATIO   = 8,
    parameter int MAX_RATIO     = 200,
    parameter int DRAIN_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       I_REF_CLK,
    input  logic       RST,
    input  logic       ENABLE,
    input  logic       CFG_VALID,
    input  logic [7:0] CFG_RATIO,
    output logic       CFG_READY,
    output logic [7:0] DIV_RATIO,
    output logic       CLK_EN,
    output logic       BUSY,
    output logic       RATIO_UPD,
    output logic       CFG_ERR
);

    localparam logic [7:0] RESET_VAL = 8'(RESET_RATIO);
    localparam logic [7:0] MAX_VAL   = 8'(MAX_RATIO);
    localparam logic [3:0] DRAIN_LD  = 4'(DRAIN_CYCLES - 1);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, LOAD, SETTLE} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [7:0] pending;
    logic       xfer;

    assign CFG_READY = !RST && (state == IDLE || state == RUN);
    assign BUSY      = !RST && (state == DRAIN || state == LOAD || state == SETTLE);
    assign xfer      = CFG_VALID && CFG_READY;

    always_ff @(posedge I_REF_CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            pending   <= 8'd0;
            DIV_RATIO <= RESET_VAL;
            CLK_EN    <= 1'b0;
            RATIO_UPD <= 1'b0;
            CFG_ERR   <= 1'b0;
        end else begin
            RATIO_UPD <= 1'b0;
            CFG_ERR   <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    // Any transfer, even a rejected or redundant one, holds the run/idle state.
                    if (xfer) begin
                        if (CFG_RATIO > MAX_VAL) begin
                            CFG_ERR <= 1'b1;
                        end else if (CFG_RATIO != DIV_RATIO) begin
                            pending <= CFG_RATIO;
                            CLK_EN  <= 1'b0;
                            if (state == RUN) begin
                                state <= DRAIN;
                                cnt   <= DRAIN_LD;
                            end else begin
                                state <= LOAD;
                            end
                        end
                    end else if (ENABLE) begin
                        state  <= RUN;
                        CLK_EN <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        CLK_EN <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (cnt == 4'd0) state <= LOAD;
                    else             cnt   <= cnt - 4'd1;
                end
                LOAD: begin
                    DIV_RATIO <= pending;
                    RATIO_UPD <= 1'b1;
                    cnt       <= SETTLE_LD;
                    state     <= SETTLE;
                end
                SETTLE: begin
                    // ENABLE is only looked at on the last settle edge.
                    if (cnt == 4'd0) begin
                        state  <= ENABLE ? RUN : IDLE;
                        CLK_EN <= ENABLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    CLK_EN <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Bench for div_ratio_ctrl: directed scenarios plus random traffic checked
// against a timeline model of ratio changes.
module tb_div_ratio_ctrl;

    localparam int RR = 8, MR = 200, DC = 2, SC = 4;

    logic       clk = 1'b0;
    logic       RST = 1'b1, ENABLE = 1'b0, CFG_VALID = 1'b0;
    logic [7:0] CFG_RATIO = 8'd0;
    logic       CFG_READY, CLK_EN, BUSY, RATIO_UPD, CFG_ERR;
    logic [7:0] DIV_RATIO;

    int total = 0, bad = 0;

    // model: a change is a timeline anchored at its accepting edge
    int         t = 0, m_e0 = 0;
    logic       m_active = 0, m_from_run = 0, m_run = 0, m_upd = 0, m_err = 0;
    logic [7:0] m_ratio = 8'(RR), m_pend = 0;

    div_ratio_ctrl #(.RESET_RATIO(RR), .MAX_RATIO(MR), .DRAIN_CYCLES(DC), .SETTLE_CYCLES(SC)) dut (
        .I_REF_CLK(clk), .RST(RST), .ENABLE(ENABLE), .CFG_VALID(CFG_VALID),
        .CFG_RATIO(CFG_RATIO), .CFG_READY(CFG_READY), .DIV_RATIO(DIV_RATIO),
        .CLK_EN(CLK_EN), .BUSY(BUSY), .RATIO_UPD(RATIO_UPD), .CFG_ERR(CFG_ERR));

    always #5 clk = ~clk;

    function automatic void model_edge();
        int k, u;
        t++;
        m_upd = 0;
        m_err = 0;
        if (RST) begin
            m_ratio = 8'(RR); m_active = 0; m_run = 0;
        end else if (m_active) begin
            k = t - m_e0;
            u = m_from_run ? DC + 1 : 1;
            if (k == u) begin m_ratio = m_pend; m_upd = 1; end
            if (k == u + SC) begin m_active = 0; m_run = ENABLE; end
        end else if (CFG_VALID) begin
            if (int'(CFG_RATIO) > MR) m_err = 1;
            else if (CFG_RATIO != m_ratio) begin
                m_active = 1; m_e0 = t; m_from_run = m_run; m_pend = CFG_RATIO; m_run = 0;
            end
        end else begin
            m_run = ENABLE;
        end
    endfunction

    task automatic tick(input logic r, input logic en, input logic v, input logic [7:0] ratio);
        RST = r; ENABLE = en; CFG_VALID = v; CFG_RATIO = ratio;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        total++; if (DIV_RATIO !== 8'd8) begin bad++; $display("FAIL rst_div got=%0d exp=8", DIV_RATIO); end
        total++; if (CLK_EN !== 1'b0) begin bad++; $display("FAIL rst_clken got=%b exp=0", CLK_EN); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
        total++; if (CFG_READY !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", CFG_READY); end
        total++; if (RATIO_UPD !== 1'b0 || CFG_ERR !== 1'b0) begin bad++; $display("FAIL rst_pulses got=%b%b exp=00", RATIO_UPD, CFG_ERR); end
    endtask

    task automatic test_enable();
        tick(0, 1, 0, 0);
        total++; if (CLK_EN !== 1'b1) begin bad++; $display("FAIL en_clken got=%b exp=1", CLK_EN); end
        total++; if (DIV_RATIO !== 8'd8) begin bad++; $display("FAIL en_div got=%0d exp=8", DIV_RATIO); end
        total++; if (CFG_READY !== 1'b1) begin bad++; $display("FAIL en_ready got=%b exp=1", CFG_READY); end
    endtask

    task automatic test_run_change();
        tick(0, 1, 1, 8'd12);
        total++; if (CLK_EN !== 1'b0 || BUSY !== 1'b1) begin bad++; $display("FAIL run_e0 got=clk%b busy%b exp=clk0 busy1", CLK_EN, BUSY); end
        for (int k = 1; k <= 7; k++) begin
            tick(0, 1, 0, 0);
            total++; if (DIV_RATIO !== ((k >= 3) ? 8'd12 : 8'd8)) begin bad++; $display("FAIL run_div k=%0d got=%0d", k, DIV_RATIO); end
            total++; if (RATIO_UPD !== (k == 3)) begin bad++; $display("FAIL run_upd k=%0d got=%b", k, RATIO_UPD); end
            total++; if (CLK_EN !== (k == 7)) begin bad++; $display("FAIL run_clken k=%0d got=%b", k, CLK_EN); end
            total++; if (BUSY !== (k < 7)) begin bad++; $display("FAIL run_busy k=%0d got=%b", k, BUSY); end
        end
    endtask

    task automatic test_idle_change();
        tick(0, 0, 0, 0);
        total++; if (CLK_EN !== 1'b0 || CFG_READY !== 1'b1) begin bad++; $display("FAIL idle_enter got=clk%b rdy%b exp=clk0 rdy1", CLK_EN, CFG_READY); end
        tick(0, 0, 1, 8'd5);
        total++; if (DIV_RATIO !== 8'd12 || BUSY !== 1'b1) begin bad++; $display("FAIL idle_e0 got=div%0d busy%b exp=div12 busy1", DIV_RATIO, BUSY); end
        for (int k = 1; k <= 5; k++) begin
            tick(0, 0, 0, 0);
            total++; if (DIV_RATIO !== 8'd5) begin bad++; $display("FAIL idle_div k=%0d got=%0d exp=5", k, DIV_RATIO); end
            total++; if (RATIO_UPD !== (k == 1)) begin bad++; $display("FAIL idle_upd k=%0d got=%b", k, RATIO_UPD); end
            total++; if (BUSY !== (k < 5) || CLK_EN !== 1'b0) begin bad++; $display("FAIL idle_busy k=%0d got=busy%b clk%b", k, BUSY, CLK_EN); end
        end
    endtask

    task automatic test_err_noop();
        tick(0, 1, 0, 0);
        tick(0, 1, 1, 8'd201);
        total++; if (CFG_ERR !== 1'b1) begin bad++; $display("FAIL err_pulse got=%b exp=1", CFG_ERR); end
        total++; if (DIV_RATIO !== 8'd5 || CLK_EN !== 1'b1 || BUSY !== 1'b0) begin bad++; $display("FAIL err_hold got=div%0d clk%b busy%b", DIV_RATIO, CLK_EN, BUSY); end
        tick(0, 1, 0, 0);
        total++; if (CFG_ERR !== 1'b0) begin bad++; $display("FAIL err_single got=%b exp=0", CFG_ERR); end
        tick(0, 0, 1, 8'd5);
        total++; if (CLK_EN !== 1'b1 || BUSY !== 1'b0 || RATIO_UPD !== 1'b0 || CFG_ERR !== 1'b0) begin
            bad++; $display("FAIL noop got=clk%b busy%b upd%b err%b exp=1000", CLK_EN, BUSY, RATIO_UPD, CFG_ERR); end
        tick(0, 1, 1, 8'd200);
        total++; if (BUSY !== 1'b1 || CFG_ERR !== 1'b0) begin bad++; $display("FAIL max_accept got=busy%b err%b exp=busy1 err0", BUSY, CFG_ERR); end
        for (int k = 1; k <= 7; k++) tick(0, 1, 0, 0);
        total++; if (DIV_RATIO !== 8'd200 || CLK_EN !== 1'b1) begin bad++; $display("FAIL max_done got=div%0d clk%b exp=div200 clk1", DIV_RATIO, CLK_EN); end
    endtask

    task automatic test_busy_hold();
        tick(0, 1, 1, 8'd30);
        for (int k = 1; k <= 7; k++) begin
            tick(0, (k < 5), 1, 8'd40);
            total++; if (CFG_READY !== (k == 7)) begin bad++; $display("FAIL hold_ready k=%0d got=%b", k, CFG_READY); end
            total++; if (DIV_RATIO !== ((k >= 3) ? 8'd30 : 8'd200)) begin bad++; $display("FAIL hold_div k=%0d got=%0d", k, DIV_RATIO); end
            total++; if (CLK_EN !== 1'b0 || BUSY !== (k < 7)) begin bad++; $display("FAIL hold_ctl k=%0d got=clk%b busy%b", k, CLK_EN, BUSY); end
        end
        tick(0, 0, 0, 0);
        total++; if (DIV_RATIO !== 8'd30 || CLK_EN !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("FAIL hold_end got=div%0d clk%b busy%b", DIV_RATIO, CLK_EN, BUSY); end
    endtask

    task automatic test_reset_abort();
        tick(0, 1, 0, 0);
        tick(0, 1, 1, 8'd20);
        tick(0, 1, 0, 0);
        tick(1, 1, 0, 0);
        total++; if (DIV_RATIO !== 8'd8 || CLK_EN !== 1'b0 || BUSY !== 1'b0 || CFG_READY !== 1'b0) begin
            bad++; $display("FAIL abort_rst got=div%0d clk%b busy%b rdy%b", DIV_RATIO, CLK_EN, BUSY, CFG_READY); end
        for (int k = 0; k < 6; k++) begin
            tick(0, 0, 0, 0);
            total++; if (DIV_RATIO !== 8'd8 || RATIO_UPD !== 1'b0 || BUSY !== 1'b0) begin
                bad++; $display("FAIL abort_after k=%0d got=div%0d upd%b busy%b", k, DIV_RATIO, RATIO_UPD, BUSY); end
        end
    endtask

    task automatic test_random();
        logic r, en, v;
        logic [7:0] ratio;
        en = 0;
        for (int c = 0; c < 1500; c++) begin
            r = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 9) == 0) en = ~en;
            v = ($urandom_range(0, 99) < 30);
            case ($urandom_range(0, 5))
                0: ratio = m_ratio;
                1: ratio = 8'($urandom_range(0, 1));
                2: ratio = 8'($urandom_range(201, 255));
                3: ratio = 8'd200;
                default: ratio = 8'($urandom_range(0, 255));
            endcase
            tick(r, en, v, ratio);
            total++; if (DIV_RATIO !== m_ratio) begin bad++; $display("FAIL rnd_div c=%0d got=%0d exp=%0d", c, DIV_RATIO, m_ratio); end
            total++; if (CLK_EN !== m_run) begin bad++; $display("FAIL rnd_clken c=%0d got=%b exp=%b", c, CLK_EN, m_run); end
            total++; if (BUSY !== (m_active && !RST)) begin bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, BUSY, m_active && !RST); end
            total++; if (CFG_READY !== (!m_active && !RST)) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, CFG_READY, !m_active && !RST); end
            total++; if (RATIO_UPD !== m_upd) begin bad++; $display("FAIL rnd_upd c=%0d got=%b exp=%b", c, RATIO_UPD, m_upd); end
            total++; if (CFG_ERR !== m_err) begin bad++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, CFG_ERR, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_run_change();
        test_idle_change();
        test_err_noop();
        test_busy_hold();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
